// File: rtl/aes_chk_pkg.sv
// aes_chk_pkg: shared widths, default pipeline latency and FSM states for the AES response checker.
package aes_chk_pkg;
    localparam int AES_BLK_W   = 128;
    localparam int CAP_W       = 64;
    localparam int DEF_LATENCY = 21;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/aes_resp_checker_if.sv
// aes_resp_checker_if: issue, response and expected-memory signals between the stimulus side and the checker.
// master: drives issue_valid/issue_last, out, Capacitance, exp_data; slave: drives exp_rd/exp_addr.
interface aes_resp_checker_if
    import aes_chk_pkg::*;
#(
    parameter int IDX_W = 8
);
    logic                 issue_valid;
    logic                 issue_last;
    logic [AES_BLK_W-1:0] out;
    logic [CAP_W-1:0]     Capacitance;
    logic [IDX_W-1:0]     exp_addr;
    logic                 exp_rd;
    logic [AES_BLK_W-1:0] exp_data;
    modport master (output issue_valid, issue_last, out, Capacitance, exp_data, input exp_addr, exp_rd);
    modport slave  (input issue_valid, issue_last, out, Capacitance, exp_data, output exp_addr, exp_rd);
endinterface

// File: rtl/aes_chk_align.sv
// aes_chk_align: {valid,last} delay line tracking issued vectors until their response is due.
// Ports: clk, rst (sync, active-high), en (shift enable; low freezes contents), in_valid/in_last,
//        pre_valid (stage LATENCY-1), cmp_valid/cmp_last (stage LATENCY).
module aes_chk_align
    import aes_chk_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic in_valid,
    input  logic in_last,
    output logic pre_valid,
    output logic cmp_valid,
    output logic cmp_last
);
    // bit i holds stage i+1
    logic [LATENCY-1:0] v;
    logic [LATENCY-1:0] l;
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            l <= '0;
        end else if (en) begin
            v <= {v[LATENCY-2:0], in_valid};
            l <= {l[LATENCY-2:0], in_valid & in_last};
        end
    end
    assign pre_valid = v[LATENCY-2];
    assign cmp_valid = v[LATENCY-1];
    assign cmp_last  = l[LATENCY-1];
endmodule

// File: rtl/aes_resp_checker.sv
// aes_resp_checker: aligns `top` responses to issued vectors, compares them with expected ciphertext and keeps a verdict.
// Ports: clk, rst (sync, active-high); bus (slave: issue_valid/issue_last, out, Capacitance, exp_rd/exp_addr/exp_data);
//        done, pass, mismatch_cnt (saturating), first_fail, fail_seen.
// AES_CAP_MONITOR_EN adds cap_nz, cap_first, cap_val and makes pass also require a quiet Capacitance.
module aes_resp_checker
    import aes_chk_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY,
    parameter int IDX_W   = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    aes_resp_checker_if.slave  bus,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   mismatch_cnt,
    output logic [IDX_W-1:0]   first_fail,
    output logic               fail_seen
`ifdef AES_CAP_MONITOR_EN
    ,
    output logic               cap_nz,
    output logic [IDX_W-1:0]   cap_first,
    output logic [CAP_W-1:0]   cap_val
`endif
);
    state_t           state;
    state_t           state_nx;
    logic             pre_valid;
    logic             cmp_valid;
    logic             cmp_last;
    logic             cmp_en;
    logic             accept;
    logic             miss;
    logic [IDX_W-1:0] cmp_idx;

    assign cmp_en = cmp_valid && state != DONE;
    // an issue landing on the cycle the last vector is compared would never be scored
    assign accept = bus.issue_valid && !(cmp_en && cmp_last);
    assign miss   = cmp_en && bus.out != bus.exp_data;

    aes_chk_align #(.LATENCY(LATENCY)) u_align (
        .clk       (clk),
        .rst       (rst),
        .en        (state != DONE),
        .in_valid  (accept),
        .in_last   (bus.issue_last),
        .pre_valid (pre_valid),
        .cmp_valid (cmp_valid),
        .cmp_last  (cmp_last)
    );

    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;

    always_comb begin
        state_nx = (state == IDLE && bus.issue_valid) ? RUN :
                   (state == RUN && cmp_en && cmp_last) ? DONE : state;
    end

    // the read is issued one cycle ahead, so it targets the vector after any compare in flight
    always_comb begin
        done         = state == DONE;
        bus.exp_rd   = pre_valid && state != DONE;
        bus.exp_addr = cmp_idx + IDX_W'(cmp_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_idx      <= '0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
            fail_seen    <= 1'b0;
        end else if (cmp_en) begin
            cmp_idx <= cmp_idx + IDX_W'(1);
            if (miss) begin
                mismatch_cnt <= &mismatch_cnt ? mismatch_cnt : mismatch_cnt + CNT_W'(1);
                first_fail   <= fail_seen ? first_fail : cmp_idx;
                fail_seen    <= 1'b1;
            end
        end
    end

`ifdef AES_CAP_MONITOR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_nz    <= 1'b0;
            cap_first <= '0;
            cap_val   <= '0;
        end else if (cmp_en && bus.Capacitance != '0 && !cap_nz) begin
            cap_nz    <= 1'b1;
            cap_first <= cmp_idx;
            cap_val   <= bus.Capacitance;
        end
    end
    assign pass = done && !fail_seen && !cap_nz;
`else
    logic cap_unused;
    assign cap_unused = ^bus.Capacitance;
    assign pass = done && !fail_seen;
`endif
endmodule

// File: tb/tb_aes_resp_checker.sv
// tb_aes_resp_checker: randomized bench with a queue-based scoreboard for aes_resp_checker (16-bit and 2-bit counters).
module tb_aes_resp_checker;
    import aes_chk_pkg::*;
    localparam int LAT = 21;
    localparam logic [127:0] AES_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct {
        int         c;
        logic       last;
        logic [7:0] idx;
    } ent_t;

    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    aes_resp_checker_if #(.IDX_W(8)) a ();
    aes_resp_checker_if #(.IDX_W(8)) b ();

    logic        a_done, a_pass, a_fs, b_done, b_pass, b_fs;
    logic [15:0] a_cnt;
    logic [1:0]  b_cnt;
    logic [7:0]  a_ff, b_ff;
`ifdef AES_CAP_MONITOR_EN
    logic        a_cnz, b_cnz;
    logic [7:0]  a_cfirst, b_cfirst;
    logic [63:0] a_cval, b_cval;
`endif

    aes_resp_checker #(.LATENCY(LAT), .IDX_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(a.slave), .done(a_done), .pass(a_pass),
        .mismatch_cnt(a_cnt), .first_fail(a_ff), .fail_seen(a_fs)
`ifdef AES_CAP_MONITOR_EN
        , .cap_nz(a_cnz), .cap_first(a_cfirst), .cap_val(a_cval)
`endif
    );

    aes_resp_checker #(.LATENCY(LAT), .IDX_W(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .bus(b.slave), .done(b_done), .pass(b_pass),
        .mismatch_cnt(b_cnt), .first_fail(b_ff), .fail_seen(b_fs)
`ifdef AES_CAP_MONITOR_EN
        , .cap_nz(b_cnz), .cap_first(b_cfirst), .cap_val(b_cval)
`endif
    );

    assign b.issue_valid = a.issue_valid;
    assign b.issue_last  = a.issue_last;
    assign b.out         = a.out;
    assign b.Capacitance = a.Capacitance;
    assign b.exp_data    = a.exp_data;

    int           cyc = 100;
    int           k = 0;
    int           cap_at = -1;
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [127:0] ct_tab [256];
    logic [127:0] mem [256];
    logic         slot_v [128];
    logic [127:0] slot_d [128];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // expected-ciphertext memory: one-cycle read latency
    always @(posedge clk) if (a.exp_rd) a.exp_data <= mem[a.exp_addr];

    // advance one cycle; the stand-in for `top` presents each vector's ciphertext LAT cycles after issue
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        a.issue_valid = 0;
        a.issue_last  = 0;
        a.out         = slot_v[(cyc - LAT) % 128] ? slot_d[(cyc - LAT) % 128] : rnd128();
        slot_v[(cyc - LAT) % 128] = 0;
        a.Capacitance = (cyc == cap_at) ? 64'h1 : 64'h0;
    endtask

    task automatic issue(input logic last);
        a.issue_valid = 1;
        a.issue_last  = last;
        slot_v[cyc % 128] = 1;
        slot_d[cyc % 128] = ct_tab[k % 256];
        k++;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
        k = 0;
        cap_at = -1;
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        while (!a_done && n < max) begin
            tick();
            n++;
        end
        chk("done_timeout", a_done, 1);
    endtask

    // scoreboard: every accepted issue is queued with its index; it is scored LAT cycles later unless done came first
    ent_t       pend [$];
    logic       m_done = 0;
    logic       m_fail = 0;
    logic       m_cnz = 0;
    int         m_cnt = 0;
    logic [7:0] m_first = 0;
    logic [7:0] m_k = 0;
    logic [7:0] m_cfirst = 0;
    logic [63:0] m_cval = 0;

    always @(negedge clk) begin : model
        logic       hc, hr, take;
        logic [7:0] ri;
        ent_t       e;
        while (pend.size() > 0 && pend[0].c < cyc - LAT) void'(pend.pop_front());
        hc = pend.size() > 0 && pend[0].c == cyc - LAT;
        hr = 0;
        ri = 0;
        foreach (pend[i]) if (pend[i].c == cyc - LAT + 1) begin hr = 1; ri = pend[i].idx; end
        chk("done", a_done, m_done);
        chk("mismatch_cnt", a_cnt, m_cnt > 65535 ? 65535 : m_cnt);
        chk("first_fail", a_ff, m_first);
        chk("fail_seen", a_fs, m_fail);
        chk("pass", a_pass, m_done && !m_fail && !m_cnz);
        chk("exp_rd", a.exp_rd, !m_done && hr);
        if (!m_done && hr) chk("exp_addr", a.exp_addr, ri);
        chk("sat_cnt", b_cnt, m_cnt > 3 ? 3 : m_cnt);
        chk("sat_done", b_done, m_done);
        chk("sat_exp_rd", b.exp_rd, !m_done && hr);
`ifdef AES_CAP_MONITOR_EN
        chk("cap_nz", a_cnz, m_cnz);
        chk("cap_first", a_cfirst, m_cfirst);
        chk("cap_val", a_cval, m_cval);
`endif
        if (rst) begin
            pend.delete();
            m_done = 0; m_fail = 0; m_cnz = 0; m_cnt = 0;
            m_first = 0; m_k = 0; m_cfirst = 0; m_cval = 0;
        end else begin
            take = a.issue_valid && !m_done && !(hc && pend[0].last);
            if (hc && !m_done) begin
                e = pend.pop_front();
                if (a.out != mem[e.idx]) begin
                    if (!m_fail) m_first = e.idx;
                    m_fail = 1;
                    m_cnt++;
                end
`ifdef AES_CAP_MONITOR_EN
                if (a.Capacitance != 0 && !m_cnz) begin
                    m_cnz = 1;
                    m_cfirst = e.idx;
                    m_cval = a.Capacitance;
                end
`endif
                if (e.last) m_done = 1;
            end
            if (take) begin
                pend.push_back('{cyc, a.issue_last, m_k});
                m_k = m_k + 1;
            end
        end
    end

    initial begin
        int n, t, i;
        a.issue_valid = 0; a.issue_last = 0; a.out = 0; a.Capacitance = 0; a.exp_data = 0;
        foreach (slot_v[j]) slot_v[j] = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
        chk("rst_done", a_done, 0);
        chk("rst_pass", a_pass, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_exp_rd", a.exp_rd, 0);

        // single known-answer vector
        ct_tab[0] = AES_CT;
        mem[0] = AES_CT;
        tick();
        issue(1);
        repeat (19) tick();
        chk("kat_rd_c19", a.exp_rd, 0);
        tick();
        chk("kat_rd_c20", a.exp_rd, 1);
        chk("kat_addr_c20", a.exp_addr, 0);
        tick();
        chk("kat_done_c21", a_done, 0);
        tick();
        chk("kat_done_c22", a_done, 1);
        chk("kat_pass", a_pass, 1);
        chk("kat_cnt", a_cnt, 0);

        // eight back-to-back, #3 and #6 corrupted in memory
        do_reset();
        for (int j = 0; j < 8; j++) begin
            ct_tab[j] = rnd128();
            mem[j] = ct_tab[j] ^ ((j == 3 || j == 6) ? 128'h1 : 128'h0);
        end
        for (int j = 0; j < 8; j++) begin
            tick();
            issue(j == 7);
        end
        wait_done(60);
        chk("b2b_cnt", a_cnt, 2);
        chk("b2b_first", a_ff, 3);
        chk("b2b_seen", a_fs, 1);
        chk("b2b_pass", a_pass, 0);

        // stimulus after done must not disturb anything
        repeat (6) begin
            tick();
            issue(1'($urandom() % 2));
        end
        repeat (LAT + 3) tick();
        chk("post_cnt", a_cnt, 2);
        chk("post_first", a_ff, 3);
        chk("post_rd", a.exp_rd, 0);

        // reset mid-run
        do_reset();
        for (int j = 0; j < 4; j++) begin
            ct_tab[j] = rnd128();
            mem[j] = ct_tab[j];
        end
        for (int j = 0; j < 4; j++) begin
            tick();
            issue(j == 3);
        end
        repeat (10) tick();
        rst = 1;
        tick();
        rst = 0;
        k = 0;
        chk("mid_rst_done", a_done, 0);
        chk("mid_rst_cnt", a_cnt, 0);
        chk("mid_rst_rd", a.exp_rd, 0);
        chk("mid_rst_addr", a.exp_addr, 0);
        chk("mid_rst_seen", a_fs, 0);
        repeat (LAT + 5) tick();
        ct_tab[0] = AES_CT;
        mem[0] = AES_CT;
        tick();
        issue(1);
        wait_done(40);
        chk("fresh_pass", a_pass, 1);

        // counter saturation on the 2-bit instance
        do_reset();
        for (int j = 0; j < 6; j++) begin
            ct_tab[j] = rnd128();
            mem[j] = ct_tab[j] ^ 128'h1;
        end
        for (int j = 0; j < 6; j++) begin
            tick();
            issue(j == 5);
        end
        wait_done(60);
        chk("sat_hold", b_cnt, 3);
        chk("sat_done_lit", b_done, 1);
        chk("sat_wide_cnt", a_cnt, 6);

        // randomized runs with gaps, stray issue_last and traffic past the last vector
        repeat (8) begin
            do_reset();
            n = $urandom_range(1, 40);
            for (int j = 0; j < 256; j++) begin
                ct_tab[j] = rnd128();
                mem[j] = ($urandom() % 4 == 0) ? ct_tab[j] ^ (128'h1 << ($urandom() % 128)) : ct_tab[j];
            end
            i = 0;
            while (i < n) begin
                tick();
                if ($urandom() % 3 == 0) a.issue_last = 1'($urandom() % 2);
                else begin
                    issue(i == n - 1);
                    i++;
                end
            end
            t = 0;
            while (!a_done && t < 80) begin
                tick();
                t++;
                if ($urandom() % 2 == 1) issue(1'($urandom() % 2));
            end
            chk("rand_done", a_done, 1);
            repeat (5) begin
                tick();
                if ($urandom() % 2 == 1) issue(0);
            end
        end

        // index wrap past 2^IDX_W
        do_reset();
        for (int j = 0; j < 256; j++) begin
            ct_tab[j] = rnd128();
            mem[j] = ct_tab[j];
        end
        mem[2] = mem[2] ^ 128'h1;
        for (int j = 0; j < 300; j++) begin
            tick();
            issue(j == 299);
        end
        wait_done(60);
        chk("wrap_cnt", a_cnt, 2);
        chk("wrap_first", a_ff, 2);

`ifdef AES_CAP_MONITOR_EN
        do_reset();
        for (int j = 0; j < 8; j++) begin
            ct_tab[j] = rnd128();
            mem[j] = ct_tab[j];
        end
        tick();
        cap_at = cyc + 5 + LAT;
        issue(0);
        for (int j = 1; j < 8; j++) begin
            tick();
            issue(j == 7);
        end
        wait_done(60);
        chk("cap_nz_lit", a_cnz, 1);
        chk("cap_first_lit", a_cfirst, 5);
        chk("cap_val_lit", a_cval, 1);
        chk("cap_pass_lit", a_pass, 0);
        chk("cap_cnt_lit", a_cnt, 0);
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
